interrupt_sequencer: RTL and testbench



---
 rtl/ps_pkg.sv | 24 ++
 rtl/return_stack.sv | 54 +++++
 rtl/interrupt_sequencer.sv | 153 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_pkg.sv
// Shared program-sequencer types: address width, jump-nibble width, ISR state.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package ps_pkg;

    localparam int PM_ADDR_W    = 8;
    localparam int JMP_NIBBLE_W = 4;

    typedef logic [PM_ADDR_W-1:0] pm_addr_t;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } isr_state_t;

    // Vector address: upper nibble is base+offset (wrapping mod 16), low bits zero.
    function automatic pm_addr_t vector_addr(input logic [JMP_NIBBLE_W-1:0] base,
                                             input logic [JMP_NIBBLE_W-1:0] offset);
        logic [JMP_NIBBLE_W-1:0] nib;
        nib = base + offset;
        return {nib, {(PM_ADDR_W-JMP_NIBBLE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address stack for interrupt nesting; push/pop take effect at the clock edge.
// Latency: top is combinational from the registered entries (0 cycles).
// Backpressure: none; push when full and pop when empty are ignored, pop wins over push.
//
// Ports: clk, reset_n (async active-low), push/push_data, pop,
//        top (current top entry, 0 when empty), depth (occupancy).
module return_stack
    import ps_pkg::*;
#(
    parameter  int STACK_DEPTH = 2,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  pm_addr_t           push_data,
    input  logic               pop,
    output pm_addr_t           top,
    output logic [DEPTH_W-1:0] depth
);

    pm_addr_t           mem [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && depth_q != '0) begin
            depth_q <= depth_q - DEPTH_W'(1);
        end else if (push && depth_q != DEPTH_W'(STACK_DEPTH)) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (depth_q == DEPTH_W'(i)) begin
                    mem[i] <= push_data;
                end
            end
            depth_q <= depth_q + DEPTH_W'(1);
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top = mem[i];
            end
        end
    end

    assign depth = depth_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Fixed-priority nested interrupt controller that redirects the program sequencer.
// Latency: irq edge -> pending next edge; ps_load/ps_load_addr combinational in the following cycle.
// Backpressure: acceptance stalls while seq_jmp/reti is active, stack is full, or priority is blocked.
//
// Ports: clk, reset_n (async active-low); irq level requests; mask_wr/mask_data enable register;
//        pc, seq_jmp, reti from the sequencer; ps_load/ps_load_addr address override;
//        pending, in_service, depth status; reti_err sticky error.
module interrupt_sequencer
    import ps_pkg::*;
#(
    parameter  int                      NUM_IRQ     = 4,
    parameter  int                      STACK_DEPTH = 2,
    parameter  logic [JMP_NIBBLE_W-1:0] VECTOR_BASE = 4'hC,
    localparam int                      DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  pm_addr_t           pc,
    input  logic               seq_jmp,
    input  logic               reti,
    output logic               ps_load,
    output pm_addr_t           ps_load_addr,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [DEPTH_W-1:0] depth,
    output logic               reti_err
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] svc_q;
    logic               err_q;
    isr_state_t         state_q;
    isr_state_t         state_nxt;

    logic               cand_vld;
    logic [IDX_W-1:0]   cand_idx;
    logic               svc_vld;
    logic [IDX_W-1:0]   svc_idx;
    logic [NUM_IRQ-1:0] cand_oh;
    logic [NUM_IRQ-1:0] svc_oh;
    logic               accept;
    logic               ret_ok;
    pm_addr_t           stack_top;
    logic [DEPTH_W-1:0] stk_depth;

    // Scan from the highest index down so the lowest index wins. The lowest
    // in-service index is both the active ISR (nesting is strictly by priority)
    // and the bit that a reti retires.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        svc_vld  = 1'b0;
        svc_idx  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i] && mask_q[i]) begin
                cand_vld = 1'b1;
                cand_idx = IDX_W'(i);
            end
            if (svc_q[i]) begin
                svc_vld = 1'b1;
                svc_idx = IDX_W'(i);
            end
        end
    end

    assign cand_oh = NUM_IRQ'(1) << cand_idx;
    assign svc_oh  = NUM_IRQ'(1) << svc_idx;

    // SERVICE is held exactly when the stack is non-empty.
    assign ret_ok = reti && (state_q == SERVICE);

    assign accept = cand_vld
                 && (!svc_vld || (cand_idx < svc_idx))
                 && (stk_depth != DEPTH_W'(STACK_DEPTH))
                 && !seq_jmp
                 && !reti;

    always_comb begin
        state_nxt    = state_q;
        ps_load      = 1'b0;
        ps_load_addr = '0;
        if (ret_ok) begin
            ps_load      = 1'b1;
            ps_load_addr = stack_top;
        end else if (accept) begin
            ps_load      = 1'b1;
            ps_load_addr = vector_addr(VECTOR_BASE, JMP_NIBBLE_W'(cand_idx));
        end
        case (state_q)
            IDLE:    if (accept) state_nxt = SERVICE;
            SERVICE: if (ret_ok && stk_depth == DEPTH_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            svc_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            irq_q  <= irq;
            // A fresh edge overrides the clear from acceptance.
            pend_q <= (pend_q & ~(accept ? cand_oh : '0)) | (irq & ~irq_q);
            if (mask_wr) begin
                mask_q <= mask_data;
            end
            if (ret_ok) begin
                svc_q <= svc_q & ~svc_oh;
            end else if (accept) begin
                svc_q <= svc_q | cand_oh;
            end
            if (reti && state_q == IDLE) begin
                err_q <= 1'b1;
            end
        end
    end

    return_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (pc + pm_addr_t'(1)),
        .pop       (ret_ok),
        .top       (stack_top),
        .depth     (stk_depth)
    );

    assign pending    = pend_q;
    assign in_service = svc_q;
    assign depth      = stk_depth;
    assign reti_err   = err_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] irq = '0;
    logic       mask_wr = 1'b0;
    logic [3:0] mask_data = '0;
    logic [7:0] pc = '0;
    logic       seq_jmp = 1'b0;
    logic       reti = 1'b0;
    logic       ps_load;
    logic [7:0] ps_load_addr;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [1:0] depth;
    logic       reti_err;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq          (irq),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .pc           (pc),
        .seq_jmp      (seq_jmp),
        .reti         (reti),
        .ps_load      (ps_load),
        .ps_load_addr (ps_load_addr),
        .pending      (pending),
        .in_service   (in_service),
        .depth        (depth),
        .reti_err     (reti_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a stack of (irq id, return address) frames plus flag vectors.
    typedef struct {
        int         id;
        logic [7:0] ret;
    } frame_t;

    frame_t     stk[$];
    bit   [3:0] m_pend, m_mask, m_irq_q;
    bit         m_err;

    logic       obs_load;
    logic [7:0] obs_addr;
    logic       obs_err;

    task automatic model_reset();
        stk.delete();
        m_pend  = '0;
        m_mask  = '0;
        m_irq_q = '0;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic cycle(input logic [3:0] i_irq, input logic i_mwr, input logic [3:0] i_mdat,
                         input logic [7:0] i_pc, input logic i_jmp, input logic i_reti);
        int         cand;
        int         min_svc;
        bit         acc;
        bit         ret;
        logic [3:0] nib;
        logic [7:0] e_addr;
        logic [3:0] e_svc;
        irq       = i_irq;
        mask_wr   = i_mwr;
        mask_data = i_mdat;
        pc        = i_pc;
        seq_jmp   = i_jmp;
        reti      = i_reti;
        @(negedge clk);
        cand = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) cand = i;
        min_svc = 4;
        e_svc   = '0;
        foreach (stk[k]) begin
            e_svc[stk[k].id] = 1'b1;
            if (stk[k].id < min_svc) min_svc = stk[k].id;
        end
        ret = i_reti && (stk.size() > 0);
        acc = (cand >= 0) && (cand < min_svc) && (stk.size() < 2) && !i_jmp && !i_reti;
        nib = 4'hC + 4'(cand);
        e_addr = ret ? stk[$].ret : (acc ? {nib, 4'h0} : 8'h00);
        check("ps_load", ps_load, acc || ret);
        check("ps_load_addr", ps_load_addr, e_addr);
        check("pending", pending, m_pend);
        check("in_service", in_service, e_svc);
        check("depth", depth, stk.size());
        check("reti_err", reti_err, m_err);
        obs_load = ps_load;
        obs_addr = ps_load_addr;
        obs_err  = reti_err;
        @(posedge clk);
        if (i_reti && stk.size() == 0) m_err = 1'b1;
        if (ret) begin
            void'(stk.pop_back());
        end else if (acc) begin
            stk.push_back('{id: cand, ret: i_pc + 8'd1});
            m_pend[cand] = 1'b0;
        end
        m_pend  = m_pend | (i_irq & ~m_irq_q);
        m_irq_q = i_irq;
        if (i_mwr) m_mask = i_mdat;
        #1;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        irq = '0; mask_wr = 1'b0; mask_data = '0; pc = '0; seq_jmp = 1'b0; reti = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_ps_load", ps_load, 1'b0);
        check("rst_addr", ps_load_addr, 8'h00);
        check("rst_pending", pending, 4'h0);
        check("rst_in_service", in_service, 4'h0);
        check("rst_depth", depth, 2'd0);
        check("rst_reti_err", reti_err, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic scen_single();
        cycle(4'h0, 1, 4'hF, 8'h05, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'h05, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'h05, 0, 0);
        check("s1_vec_load", obs_load, 1'b1);
        check("s1_vec_addr", obs_addr, 8'hE0);
        cycle(4'h4, 0, 4'h0, 8'hE0, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'hE1, 0, 1);
        check("s1_ret_addr", obs_addr, 8'h06);
        cycle(4'h0, 0, 4'h0, 8'h06, 0, 0);
    endtask

    logic [3:0] r_irq;

    initial begin
        do_reset();
        scen_single();

        // Preemption of IRQ2 by IRQ0.
        cycle(4'h4, 0, 4'h0, 8'h10, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'h10, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'hE3, 0, 0);
        cycle(4'h5, 0, 4'h0, 8'hE3, 0, 0);
        cycle(4'h5, 0, 4'h0, 8'hE3, 0, 0);
        check("s2_vec", obs_addr, 8'hC0);
        cycle(4'h5, 0, 4'h0, 8'hC0, 0, 0);
        cycle(4'h5, 0, 4'h0, 8'hC1, 0, 1);
        check("s2_ret1", obs_addr, 8'hE4);
        cycle(4'h5, 0, 4'h0, 8'hE4, 0, 1);
        check("s2_ret2", obs_addr, 8'h11);
        cycle(4'h0, 0, 4'h0, 8'h11, 0, 0);

        // Lower priority waits for the return.
        cycle(4'h2, 0, 4'h0, 8'h20, 0, 0);
        cycle(4'h2, 0, 4'h0, 8'h20, 0, 0);
        cycle(4'hA, 0, 4'h0, 8'hD0, 0, 0);
        cycle(4'hA, 0, 4'h0, 8'hD1, 0, 0);
        check("s3_blocked", obs_load, 1'b0);
        cycle(4'hA, 0, 4'h0, 8'hD2, 0, 1);
        check("s3_ret", obs_addr, 8'h21);
        cycle(4'hA, 0, 4'h0, 8'h21, 0, 0);
        check("s3_vec", obs_addr, 8'hF0);
        cycle(4'h0, 0, 4'h0, 8'hF0, 0, 1);
        cycle(4'h0, 0, 4'h0, 8'h22, 0, 0);

        // seq_jmp interlock.
        cycle(4'h2, 0, 4'h0, 8'h30, 0, 0);
        cycle(4'h2, 0, 4'h0, 8'h31, 1, 0);
        check("s4_jmp_hold", obs_load, 1'b0);
        cycle(4'h2, 0, 4'h0, 8'h32, 0, 0);
        check("s4_vec", obs_addr, 8'hD0);
        cycle(4'h2, 0, 4'h0, 8'hD0, 0, 1);
        check("s4_ret", obs_addr, 8'h33);
        cycle(4'h0, 0, 4'h0, 8'h33, 0, 0);

        // Masked request persists, accepted after unmasking.
        cycle(4'h0, 1, 4'h0, 8'h40, 0, 0);
        cycle(4'h2, 0, 4'h0, 8'h40, 0, 0);
        cycle(4'h2, 0, 4'h0, 8'h41, 0, 0);
        check("s5_masked", obs_load, 1'b0);
        cycle(4'h2, 1, 4'h2, 8'h42, 0, 0);
        cycle(4'h2, 0, 4'h0, 8'h43, 0, 0);
        check("s5_vec", obs_addr, 8'hD0);
        cycle(4'h2, 1, 4'hF, 8'hD0, 0, 1);
        check("s5_ret", obs_addr, 8'h44);
        cycle(4'h0, 0, 4'h0, 8'h44, 0, 0);

        // pc wrap and stack full.
        cycle(4'h4, 0, 4'h0, 8'hFF, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'hFF, 0, 0);
        cycle(4'h6, 0, 4'h0, 8'hE0, 0, 0);
        cycle(4'h6, 0, 4'h0, 8'hE0, 0, 0);
        cycle(4'h7, 0, 4'h0, 8'hD0, 0, 0);
        cycle(4'h7, 0, 4'h0, 8'hD1, 0, 0);
        check("s6_full_hold", obs_load, 1'b0);
        cycle(4'h7, 0, 4'h0, 8'hD2, 0, 1);
        check("s6_ret1", obs_addr, 8'hE1);
        cycle(4'h7, 0, 4'h0, 8'hE1, 0, 0);
        check("s6_vec", obs_addr, 8'hC0);
        cycle(4'h7, 0, 4'h0, 8'hC0, 0, 1);
        cycle(4'h7, 0, 4'h0, 8'hE2, 0, 1);
        check("s6_wrap", obs_addr, 8'h00);
        cycle(4'h0, 0, 4'h0, 8'h00, 0, 0);

        // reti with nothing to return to.
        cycle(4'h0, 0, 4'h0, 8'h50, 0, 1);
        check("s7_no_load", obs_load, 1'b0);
        cycle(4'h0, 0, 4'h0, 8'h51, 0, 0);
        check("s7_err", obs_err, 1'b1);

        // Randomised traffic.
        r_irq = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r_irq[b] = ~r_irq[b];
            end
            cycle(r_irq, $urandom_range(0, 15) == 0,
                  4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)),
                  8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

        // Reset in the middle of a nest, then a fresh request.
        cycle(4'h0, 1, 4'hF, 8'h60, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'h60, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'h61, 0, 0);
        cycle(4'h4, 0, 4'h0, 8'h62, 0, 0);
        check("nest_before_reset", depth != 2'd0, 1'b1);
        do_reset();
        scen_single();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
